// File: rtl/flag_stack_register_if.sv
// Flag-register bus: ALU/control-unit side signals of flag_stack_register.
// master = control unit / ALU side, slave = the flag register itself.
interface flag_stack_register_if #(
  parameter int NR_FLAGS    = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic                CLR_FLAG;
  logic [NR_FLAGS-1:0] FLAG_EN;
  logic [NR_FLAGS-1:0] FLAG_IN;
  logic                PUSH;
  logic                POP;
  logic                CLR_ERR;
  logic [NR_FLAGS-1:0] FLAG_OUT;
  logic [LVL_W-1:0]    STK_LEVEL;
  logic                STK_FULL;
  logic                STK_EMPTY;
  logic                STK_OVF;
  logic                STK_UNF;

  modport master (
    output CLR_FLAG, FLAG_EN, FLAG_IN, PUSH, POP, CLR_ERR,
    input  FLAG_OUT, STK_LEVEL, STK_FULL, STK_EMPTY, STK_OVF, STK_UNF
  );

  modport slave (
    input  CLR_FLAG, FLAG_EN, FLAG_IN, PUSH, POP, CLR_ERR,
    output FLAG_OUT, STK_LEVEL, STK_FULL, STK_EMPTY, STK_OVF, STK_UNF
  );
endinterface

// File: rtl/flag_stack_register.sv
// Status-flag register with per-bit load enables, synchronous clear and a
// single-cycle save/restore LIFO for interrupt entry/return.
// Optional macro FLAG_STACK_ERR_EN: implements sticky STK_OVF/STK_UNF and
// CLR_ERR; without it both error outputs are tied to 0.
module flag_stack_register #(
  parameter int NR_FLAGS    = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic                    CLK,
  input logic                    CLR_N,
  flag_stack_register_if.slave   bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [NR_FLAGS-1:0] flags_reg;
  logic [NR_FLAGS-1:0] flags_next;
  logic [NR_FLAGS-1:0] top_word;
  logic [NR_FLAGS-1:0] stack_reg [STACK_DEPTH];
  logic [LVL_W-1:0]    lvl_reg;
  logic [LVL_W-1:0]    lvl_next;
  logic [LVL_W-1:0]    top_idx;
  logic [LVL_W-1:0]    wr_idx;
  logic                full;
  logic                empty;
  logic                pop_ok;
  logic                push_ok;
  logic                swap;
  logic                wr_en;

  assign full    = (lvl_reg == LVL_W'(STACK_DEPTH));
  assign empty   = (lvl_reg == '0);
  assign top_idx = lvl_reg - LVL_W'(1);

  // PUSH+POP on a non-empty stack exchanges top and live flags; on an
  // empty stack it degrades to a plain PUSH.
  assign swap    = bus.PUSH & bus.POP & ~empty;
  assign pop_ok  = bus.POP & ~empty;
  assign push_ok = bus.PUSH & ~full & (~bus.POP | empty);
  assign wr_en   = push_ok | swap;
  assign wr_idx  = swap ? top_idx : lvl_reg;

  // Read mux for the current top-of-stack entry.
  always_comb begin
    top_word = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (top_idx == LVL_W'(i)) top_word = stack_reg[i];
    end
  end

  // Next flags: restore beats clear, clear beats per-bit load.
  always_comb begin
    if (pop_ok)            flags_next = top_word;
    else if (bus.CLR_FLAG) flags_next = '0;
    else                   flags_next = (flags_reg & ~bus.FLAG_EN) | (bus.FLAG_IN & bus.FLAG_EN);
  end

  // Next level: swap leaves the level unchanged.
  always_comb begin
    if (push_ok)            lvl_next = lvl_reg + LVL_W'(1);
    else if (pop_ok & ~swap) lvl_next = lvl_reg - LVL_W'(1);
    else                    lvl_next = lvl_reg;
  end

  // Live flags and stack level.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      flags_reg <= '0;
      lvl_reg   <= '0;
    end else begin
      flags_reg <= flags_next;
      lvl_reg   <= lvl_next;
    end
  end

  // Stack storage; always saves the pre-edge flags, popped entries keep data.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (wr_en && (wr_idx == LVL_W'(i))) stack_reg[i] <= flags_reg;
      end
    end
  end

`ifdef FLAG_STACK_ERR_EN
  logic ovf_reg;
  logic unf_reg;
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = bus.PUSH & ~bus.POP & full;
  assign unf_evt = bus.POP & ~bus.PUSH & empty;

  // Sticky error bits; a new event wins over CLR_ERR in the same cycle.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_evt | (ovf_reg & ~bus.CLR_ERR);
      unf_reg <= unf_evt | (unf_reg & ~bus.CLR_ERR);
    end
  end

  assign bus.STK_OVF = ovf_reg;
  assign bus.STK_UNF = unf_reg;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.CLR_ERR;
  assign bus.STK_OVF    = 1'b0;
  assign bus.STK_UNF    = 1'b0;
`endif

  assign bus.FLAG_OUT  = flags_reg;
  assign bus.STK_LEVEL = lvl_reg;
  assign bus.STK_FULL  = full;
  assign bus.STK_EMPTY = empty;
endmodule

// File: tb/tb_flag_stack_register.sv
// Directed self-checking bench for flag_stack_register (NR_FLAGS=4, DEPTH=4).
// Error-bit expectations follow the FLAG_STACK_ERR_EN macro of the build.
module tb_flag_stack_register;
`ifdef FLAG_STACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic clr_n;
  int   checks;
  int   errors;

  flag_stack_register_if #(.NR_FLAGS(4), .STACK_DEPTH(4)) bus ();

  flag_stack_register #(.NR_FLAGS(4), .STACK_DEPTH(4)) dut (
    .CLK   (clk),
    .CLR_N (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s value=%0h at %0t", tag, got, $time);
    end
  endtask

  // Apply current inputs across one rising edge; sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic push, input logic pop, input logic clr_flag,
                       input logic [3:0] en, input logic [3:0] din, input logic clr_err);
    bus.PUSH     = push;
    bus.POP      = pop;
    bus.CLR_FLAG = clr_flag;
    bus.FLAG_EN  = en;
    bus.FLAG_IN  = din;
    bus.CLR_ERR  = clr_err;
  endtask

  initial begin
    logic [3:0] ovf_in [5];
    logic [3:0] ovf_exp [4];
    checks = 0;
    errors = 0;
    clr_n  = 1'b0;
    drive(0, 0, 0, 4'h0, 4'h0, 0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_flags", 32'(bus.FLAG_OUT), 32'h0);
    check("rst_level", 32'(bus.STK_LEVEL), 32'h0);
    check("rst_empty", 32'(bus.STK_EMPTY), 32'h1);
    check("rst_full",  32'(bus.STK_FULL), 32'h0);
    check("rst_ovf",   32'(bus.STK_OVF), 32'h0);
    check("rst_unf",   32'(bus.STK_UNF), 32'h0);
    clr_n = 1'b1;

    // Per-bit load then hold
    drive(0, 0, 0, 4'b0101, 4'b1111, 0); step();
    check("load_masked", 32'(bus.FLAG_OUT), 32'h5);
    drive(0, 0, 0, 4'b0000, 4'b1010, 0); step();
    check("load_hold", 32'(bus.FLAG_OUT), 32'h5);

    // Push/pop order
    drive(0, 0, 0, 4'hF, 4'h1, 0); step();
    check("pp_flags1", 32'(bus.FLAG_OUT), 32'h1);
    drive(1, 0, 0, 4'hF, 4'h2, 0); step();
    check("pp_level1", 32'(bus.STK_LEVEL), 32'h1);
    check("pp_flags2", 32'(bus.FLAG_OUT), 32'h2);
    drive(1, 0, 0, 4'hF, 4'h3, 0); step();
    check("pp_level2", 32'(bus.STK_LEVEL), 32'h2);
    check("pp_flags3", 32'(bus.FLAG_OUT), 32'h3);
    drive(0, 1, 0, 4'h0, 4'h0, 0); step();
    check("pop1_flags", 32'(bus.FLAG_OUT), 32'h2);
    check("pop1_level", 32'(bus.STK_LEVEL), 32'h1);
    // Valid POP outranks CLR_FLAG
    drive(0, 1, 1, 4'hF, 4'hF, 0); step();
    check("pop2_flags", 32'(bus.FLAG_OUT), 32'h1);
    check("pop2_level", 32'(bus.STK_LEVEL), 32'h0);
    check("pop2_empty", 32'(bus.STK_EMPTY), 32'h1);

    // Overflow: five pushes, flags loaded with new values each cycle
    ovf_in  = '{4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    ovf_exp = '{4'h8, 4'h7, 4'h6, 4'h1};
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 4'hF, ovf_in[i], 0); step();
    end
    check("ovf_level", 32'(bus.STK_LEVEL), 32'h4);
    check("ovf_full",  32'(bus.STK_FULL), 32'h1);
    check("ovf_flag",  32'(bus.STK_OVF), 32'(ERR_EN));
    check("ovf_flags", 32'(bus.FLAG_OUT), 32'hA);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 4'h0, 4'h0, 0); step();
      check($sformatf("ovf_pop%0d_flags", i), 32'(bus.FLAG_OUT), 32'(ovf_exp[i]));
      check($sformatf("ovf_pop%0d_level", i), 32'(bus.STK_LEVEL), 32'(3 - i));
    end
    check("ovf_sticky", 32'(bus.STK_OVF), 32'(ERR_EN));
    drive(0, 0, 0, 4'h0, 4'h0, 1); step();
    check("ovf_cleared", 32'(bus.STK_OVF), 32'h0);

    // Underflow with CLR_FLAG priority; set beats clear; then clear
    drive(0, 1, 1, 4'hF, 4'hF, 0); step();
    check("unf_flags", 32'(bus.FLAG_OUT), 32'h0);
    check("unf_flag",  32'(bus.STK_UNF), 32'(ERR_EN));
    check("unf_level", 32'(bus.STK_LEVEL), 32'h0);
    drive(0, 1, 0, 4'h0, 4'h0, 1); step();
    check("unf_set_wins", 32'(bus.STK_UNF), 32'(ERR_EN));
    drive(0, 0, 0, 4'h0, 4'h0, 1); step();
    check("unf_cleared", 32'(bus.STK_UNF), 32'h0);

    // PUSH+POP on empty acts as PUSH, then swap
    drive(0, 0, 0, 4'hF, 4'hA, 0); step();
    drive(1, 1, 0, 4'hF, 4'h5, 0); step();
    check("pe_level", 32'(bus.STK_LEVEL), 32'h1);
    check("pe_flags", 32'(bus.FLAG_OUT), 32'h5);
    check("pe_no_unf", 32'(bus.STK_UNF), 32'h0);
    drive(1, 1, 0, 4'h0, 4'h0, 0); step();
    check("swap_flags", 32'(bus.FLAG_OUT), 32'hA);
    check("swap_level", 32'(bus.STK_LEVEL), 32'h1);
    drive(0, 1, 0, 4'h0, 4'h0, 0); step();
    check("swap_entry", 32'(bus.FLAG_OUT), 32'h5);
    check("swap_empty", 32'(bus.STK_EMPTY), 32'h1);

    // Async reset mid-cycle with level 3
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'hF, 4'(i + 1), 0); step();
    end
    check("ar_level_pre", 32'(bus.STK_LEVEL), 32'h3);
    check("ar_flags_pre", 32'(bus.FLAG_OUT), 32'h3);
    drive(0, 1, 0, 4'h0, 4'h0, 0);
    #2 clr_n = 1'b0;
    #1;
    check("ar_flags", 32'(bus.FLAG_OUT), 32'h0);
    check("ar_level", 32'(bus.STK_LEVEL), 32'h0);
    check("ar_empty", 32'(bus.STK_EMPTY), 32'h1);
    @(negedge clk);
    check("ar_held", 32'(bus.STK_LEVEL), 32'h0);
    clr_n = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0, 0); step();
    check("ar_after", 32'(bus.FLAG_OUT), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_stack_register.md
# flag_stack_register

Parametrised processor status-flag register with per-flag write enables, synchronous flag clear, and a hardware save/restore stack for interrupt entry and return. It sits between the ALU flag outputs and the control unit / branch logic. It replaces the fixed 4-flag, 3-enable flag register. PUSH saves the live flags and POP restores them in a single cycle, so no microcode flag save is needed.

## Interface
- NR_FLAGS, 4: number of flag bits (1..16).
- STACK_DEPTH, 4: number of saved flag words (1..16).
- LVL_W, $clog2(STACK_DEPTH+1): width of STK_LEVEL (derived, not overridden).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- CLR_N  in  1  reset. One clock; reset is asynchronous and active-low.
- CLR_FLAG  in  1  synchronous clear of FLAG_OUT (stack untouched).
- FLAG_EN  in  NR_FLAGS  per-bit load enable for FLAG_IN.
- FLAG_IN  in  NR_FLAGS  new flag values from ALU.
- PUSH  in  1  save current FLAG_OUT onto stack.
- POP  in  1  restore top of stack into FLAG_OUT.
- CLR_ERR  in  1  synchronous clear of sticky error bits.
- FLAG_OUT  out  NR_FLAGS  live flags (registered).
- STK_LEVEL  out  LVL_W  number of valid stack entries.
- STK_FULL  out  1  STK_LEVEL == STACK_DEPTH (combinational from level).
- STK_EMPTY  out  1  STK_LEVEL == 0.
- STK_OVF  out  1  sticky: PUSH attempted while full.
- STK_UNF  out  1  sticky: POP attempted while empty.

## Operation
- Reset (CLR_N low, any time, asynchronous): FLAG_OUT=0, STK_LEVEL=0, STK_EMPTY=1, STK_FULL=0, STK_OVF=0, STK_UNF=0, all stack entries 0. Reset mid-PUSH or mid-POP discards that operation.
- Next FLAG_OUT, priority highest first:
  - valid POP: top entry.
  - CLR_FLAG: all zero.
  - otherwise, per bit i: FLAG_IN[i] if FLAG_EN[i], else hold.
- PUSH always stores the pre-edge FLAG_OUT, so an update in the same cycle does not affect the saved word.
- Stack is a LIFO addressed by STK_LEVEL; the entry at index STK_LEVEL-1 is the top.
- Cases:
  - PUSH only, not full: write entry[level], level+1.
  - PUSH only, full: ignored; STK_OVF set.
  - POP only, not empty: FLAG_OUT takes entry[level-1], level-1.
  - POP only, empty: ignored; FLAG_OUT follows CLR_FLAG/FLAG_EN rules; STK_UNF set.
  - PUSH and POP, not empty: swap. entry[level-1] takes the old FLAG_OUT, FLAG_OUT takes the old entry[level-1], level unchanged.
  - PUSH and POP, empty: treated as PUSH only; no underflow is flagged.
- CLR_ERR clears both sticky bits. If an error event occurs in the same cycle, the error bit is set (set wins).
- A popped entry's storage is not cleared; only STK_LEVEL changes.

## Timing
- Every output is registered, or decoded only from registered STK_LEVEL. There is no combinational path from inputs to outputs.
- All inputs are sampled at the rising CLK edge. Results are visible one cycle later (latency 1).
- Back-to-back PUSH/POP on consecutive cycles is supported at full rate. No handshake or stall exists.
- FLAG_IN and FLAG_EN are don't-care when POP is valid or CLR_FLAG=1.

## Configuration
- FLAG_STACK_ERR_EN defined:
  - STK_OVF and STK_UNF are implemented as sticky registers.
  - CLR_ERR is functional.
- FLAG_STACK_ERR_EN undefined:
  - STK_OVF and STK_UNF are tied to 0 and CLR_ERR is ignored.
  - Overflow and underflow operations are still ignored exactly as above; only error reporting is removed.

## Test plan
- Reset/load (NR_FLAGS=4): release CLR_N, set FLAG_EN=4'b0101 and FLAG_IN=4'b1111. Next cycle FLAG_OUT=4'b0101. Then FLAG_EN=0 with any FLAG_IN holds 4'b0101.
- Push/pop order: flags 4'h1, PUSH; flags 4'h2, PUSH; flags 4'h3. POP gives FLAG_OUT=4'h2 and STK_LEVEL=1. POP again gives FLAG_OUT=4'h1, STK_LEVEL=0, STK_EMPTY=1.
- Overflow (DEPTH=4): 5 PUSHes. STK_LEVEL stays 4 and STK_FULL=1. STK_OVF=1 with the macro defined, 0 without. 4 POPs then return the first 4 pushed words in reverse order.
- Underflow/priority: POP while empty with CLR_FLAG=1 gives FLAG_OUT=0 and STK_UNF=1. CLR_ERR the next cycle clears STK_UNF.
- Swap: level=1 holding 4'hA, FLAG_OUT=4'h5, PUSH+POP together. FLAG_OUT=4'hA, the stored entry becomes 4'h5, level stays 1.
- Async reset: assert CLR_N mid-cycle with level=3. Outputs go to reset values immediately, without waiting for a CLK edge.
